// File: rtl/irq_capture_rr_4.sv
// Four-line interrupt capture with a round-robin registered one-hot grant.
// The grant vector feeds encoder_4_2 and stays zero while no offer is open.
module irq_capture_rr_4 #(
    parameter int N    = 4,
    parameter bit EDGE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] clr,
    output logic [N-1:0] grant,
    output logic         grant_valid,
    input  logic         grant_ready,
    output logic [N-1:0] pending,
    output logic [N-1:0] overflow
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OFFER = 1'b1;

    logic [0:0]   state;
    logic [1:0]   ptr;
    logic [1:0]   gidx;
    logic [N-1:0] req_q;
    logic [N-1:0] rise;
    logic [N-1:0] acc;
    logic [N-1:0] pending_nxt;
    logic [N-1:0] overflow_nxt;
    logic [N-1:0] rot;
    logic [1:0]   sel_off;
    logic [1:0]   sel;
    logic         sel_hit;
    logic [N-1:0] sel_onehot;

    generate
        if (EDGE) begin : g_edge
            assign rise = req & ~req_q;
        end else begin : g_level
            assign rise = req;
        end
    endgenerate

    assign acc = (grant_valid && grant_ready) ? grant : '0;

    // Set wins over a same-cycle acceptance; clear wins over both.
    always_comb begin
        pending_nxt  = pending;
        overflow_nxt = overflow;
        for (int i = 0; i < N; i++) begin
            if (clr[i]) begin
                pending_nxt[i]  = 1'b0;
                overflow_nxt[i] = 1'b0;
            end else begin
                if (rise[i]) begin
                    pending_nxt[i] = 1'b1;
                end else if (acc[i]) begin
                    pending_nxt[i] = 1'b0;
                end
                if (rise[i] && pending[i] && !acc[i]) begin
                    overflow_nxt[i] = 1'b1;
                end
            end
        end
    end

    // Rotate so rot[0] is the bit at ptr, then take the lowest set offset.
    always_comb begin
        rot = '0;
        for (int k = 0; k < N; k++) begin
            rot[k] = pending[2'(ptr + 2'(k))];
        end
    end

    always_comb begin
        sel_off = 2'd0;
        sel_hit = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sel_off = 2'(k);
                sel_hit = 1'b1;
            end
        end
    end

    assign sel        = ptr + sel_off;
    assign sel_onehot = N'(1) << sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 2'd0;
            gidx        <= 2'd0;
            req_q       <= '0;
            pending     <= '0;
            overflow    <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
        end else begin
            req_q    <= req;
            pending  <= pending_nxt;
            overflow <= overflow_nxt;
            case (state)
                IDLE: begin
                    if (sel_hit) begin
                        grant       <= sel_onehot;
                        grant_valid <= 1'b1;
                        gidx        <= sel;
                        state       <= OFFER;
                    end
                end
                OFFER: begin
                    if (grant_ready) begin
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        ptr         <= gidx + 2'd1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_capture_rr_4.sv
// Bench for irq_capture_rr_4: edge and level instances against a
// cycle model built from the capture/arbitration rules.
module tb_irq_capture_rr_4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] clr = '0;
    logic       grant_ready = 1'b0;

    logic [3:0] grant_e, pending_e, overflow_e;
    logic       grant_valid_e;
    logic [3:0] grant_l, pending_l, overflow_l;
    logic       grant_valid_l;

    int ncmp = 0;
    int nerr = 0;

    // reference state, index 0 = edge mode, 1 = level mode
    logic [3:0] m_pend [2];
    logic [3:0] m_ovf  [2];
    logic [3:0] m_rq   [2];
    bit         m_off  [2];
    int         m_g    [2];
    int         m_ptr  [2];

    always #5 clk = ~clk;

    irq_capture_rr_4 #(.N(4), .EDGE(1'b1)) dut_e (
        .clk(clk), .rst(rst), .req(req), .clr(clr),
        .grant(grant_e), .grant_valid(grant_valid_e),
        .grant_ready(grant_ready),
        .pending(pending_e), .overflow(overflow_e)
    );

    irq_capture_rr_4 #(.N(4), .EDGE(1'b0)) dut_l (
        .clk(clk), .rst(rst), .req(req), .clr(clr),
        .grant(grant_l), .grant_valid(grant_valid_l),
        .grant_ready(grant_ready),
        .pending(pending_l), .overflow(overflow_l)
    );

    task automatic chk(input string tag, input logic [3:0] got,
                       input logic [3:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic model_step(input int m, input bit edge_mode);
        logic [3:0] rise, acc, np, no;
        bit found;
        if (rst) begin
            m_pend[m] = '0;
            m_ovf[m]  = '0;
            m_rq[m]   = '0;
            m_off[m]  = 1'b0;
            m_g[m]    = 0;
            m_ptr[m]  = 0;
        end else begin
            rise = edge_mode ? (req & ~m_rq[m]) : req;
            acc  = (m_off[m] && grant_ready) ? 4'(1 << m_g[m]) : 4'b0;
            np = m_pend[m];
            no = m_ovf[m];
            for (int i = 0; i < 4; i++) begin
                if (clr[i]) begin
                    np[i] = 1'b0;
                    no[i] = 1'b0;
                end else begin
                    if (rise[i]) np[i] = 1'b1;
                    else if (acc[i]) np[i] = 1'b0;
                    if (rise[i] && m_pend[m][i] && !acc[i]) no[i] = 1'b1;
                end
            end
            if (!m_off[m]) begin
                found = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    int idx;
                    idx = (m_ptr[m] + k) % 4;
                    if (!found && m_pend[m][idx]) begin
                        found    = 1'b1;
                        m_off[m] = 1'b1;
                        m_g[m]   = idx;
                    end
                end
            end else if (grant_ready) begin
                m_off[m] = 1'b0;
                m_ptr[m] = (m_g[m] + 1) % 4;
            end
            m_pend[m] = np;
            m_ovf[m]  = no;
            m_rq[m]   = req;
        end
    endtask

    function automatic logic [3:0] m_grant(input int m);
        return m_off[m] ? 4'(1 << m_g[m]) : 4'b0;
    endfunction

    task automatic check_all();
        chk("e_grant", grant_e, m_grant(0));
        chk("e_valid", {3'b0, grant_valid_e}, {3'b0, m_off[0]});
        chk("e_pend", pending_e, m_pend[0]);
        chk("e_ovf", overflow_e, m_ovf[0]);
        chk("l_grant", grant_l, m_grant(1));
        chk("l_valid", {3'b0, grant_valid_l}, {3'b0, m_off[1]});
        chk("l_pend", pending_l, m_pend[1]);
        chk("l_ovf", overflow_l, m_ovf[1]);
    endtask

    task automatic tick(input logic [3:0] r, input logic [3:0] c,
                        input logic rd, input logic rs);
        req = r;
        clr = c;
        grant_ready = rd;
        rst = rs;
        @(posedge clk);
        model_step(0, 1'b1);
        model_step(1, 1'b0);
        #1;
        check_all();
    endtask

    initial begin
        // reset hold with all requests high, then edge capture on release
        tick(4'b1111, 4'b0, 1'b1, 1'b1);
        tick(4'b1111, 4'b0, 1'b1, 1'b1);
        chk("t1_rst_pend", pending_e, 4'b0000);
        chk("t1_rst_valid", {3'b0, grant_valid_e}, 4'b0000);
        tick(4'b1111, 4'b0, 1'b1, 1'b0);
        chk("t1_pend", pending_e, 4'b1111);
        tick(4'b1111, 4'b0, 1'b1, 1'b0);
        chk("t1_g0", grant_e, 4'b0001);
        tick(4'b1111, 4'b0, 1'b1, 1'b0);
        chk("t1_idle", grant_e, 4'b0000);
        tick(4'b1111, 4'b0, 1'b1, 1'b0);
        chk("t1_g1", grant_e, 4'b0010);
        for (int n = 0; n < 5; n++) tick(4'b1111, 4'b0, 1'b1, 1'b0);
        chk("t1_drain", pending_e, 4'b0000);

        // latency and hold
        tick(4'b0000, 4'b0, 1'b0, 1'b1);
        tick(4'b0100, 4'b0, 1'b0, 1'b0);
        chk("t2_pend", pending_e, 4'b0100);
        tick(4'b0000, 4'b0, 1'b0, 1'b0);
        chk("t2_grant", grant_e, 4'b0100);
        for (int n = 0; n < 5; n++) tick(4'b0000, 4'b0, 1'b0, 1'b0);
        chk("t2_hold", grant_e, 4'b0100);
        tick(4'b0000, 4'b0, 1'b1, 1'b0);
        chk("t2_acc_valid", {3'b0, grant_valid_e}, 4'b0000);
        chk("t2_acc_pend", pending_e, 4'b0000);

        // round-robin: after ptr reaches 2, bit 0 wins over bit 1
        tick(4'b0000, 4'b0, 1'b1, 1'b1);
        tick(4'b0011, 4'b0, 1'b1, 1'b0);
        tick(4'b0000, 4'b0, 1'b1, 1'b0);
        chk("t3_g0", grant_e, 4'b0001);
        tick(4'b0000, 4'b0, 1'b1, 1'b0);
        tick(4'b0000, 4'b0, 1'b1, 1'b0);
        chk("t3_g1", grant_e, 4'b0010);
        tick(4'b0000, 4'b0, 1'b1, 1'b0);
        tick(4'b0011, 4'b0, 1'b1, 1'b0);
        tick(4'b0000, 4'b0, 1'b1, 1'b0);
        chk("t3_wrap", grant_e, 4'b0001);

        // overflow and clear under an open offer
        tick(4'b0000, 4'b0, 1'b0, 1'b1);
        tick(4'b0010, 4'b0, 1'b0, 1'b0);
        tick(4'b0000, 4'b0, 1'b0, 1'b0);
        tick(4'b0010, 4'b0, 1'b0, 1'b0);
        chk("t4_ovf", overflow_e, 4'b0010);
        chk("t4_pend", pending_e, 4'b0010);
        tick(4'b0000, 4'b0010, 1'b0, 1'b0);
        chk("t4_clr_ovf", overflow_e, 4'b0000);
        chk("t4_clr_pend", pending_e, 4'b0000);
        chk("t4_offer", grant_e, 4'b0010);
        tick(4'b0000, 4'b0, 1'b1, 1'b0);
        chk("t4_done", {3'b0, grant_valid_e}, 4'b0000);

        // set beats accept
        tick(4'b0000, 4'b0, 1'b1, 1'b1);
        tick(4'b0100, 4'b0, 1'b1, 1'b0);
        tick(4'b0000, 4'b0, 1'b1, 1'b0);
        tick(4'b0100, 4'b0, 1'b1, 1'b0);
        chk("t5_pend", pending_e, 4'b0100);
        chk("t5_ovf", overflow_e, 4'b0000);
        chk("t5_idle", grant_e, 4'b0000);
        tick(4'b0000, 4'b0, 1'b1, 1'b0);
        chk("t5_regrant", grant_e, 4'b0100);

        // level mode re-grants a held request and flags overflow
        tick(4'b0000, 4'b0, 1'b1, 1'b1);
        for (int n = 0; n < 8; n++) tick(4'b1000, 4'b0, 1'b1, 1'b0);
        chk("t6_ovf", overflow_l, 4'b1000);
        chk("t6_pend", pending_l, 4'b1000);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [3:0] r, c;
            r = 4'($urandom_range(0, 15));
            c = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15))
                                             : 4'b0;
            tick(r, c, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 63) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule
